// File: rtl/fbindct_if.sv
// Streaming port bundle for the 8-point forward binDCT pipeline.
// The input side carries one 8-sample vector plus a LAST flag; the output
// side carries the 8 coefficients plus the same LAST flag. Lane i of x_in /
// y_out occupies bits [i*W +: W] of the packed vector.
interface fbindct_if #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 18
);
    logic [7:0][IN_WIDTH-1:0]  x_in;
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_last;
    logic [7:0][OUT_WIDTH-1:0] y_out;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;

    // The transform block: consumes vectors, produces coefficients.
    modport slave (
        input  x_in, in_valid, in_last, out_ready,
        output in_ready, y_out, out_valid, out_last
    );

    // The environment: produces vectors, consumes coefficients.
    modport master (
        output x_in, in_valid, in_last, out_ready,
        input  in_ready, y_out, out_valid, out_last
    );
endinterface

// File: rtl/fbindct_pipe.sv
// Fully pipelined 8-point forward binDCT built from lifting steps
// (shifts and adds only). One vector per cycle, four register stages,
// valid/ready flow control with bubble collapse, LAST sideband carried
// alongside each vector, optional rounding of the outputs to integers.
//
// Handshake: a vector moves across the input port on a rising edge where
// in_valid & in_ready are both 1, and across the output port where
// out_valid & out_ready are both 1. While out_valid=1 and out_ready=0 the
// output (y_out, out_last) holds its value. in_ready depends on out_ready
// combinationally through the stage ready chain, never on in_valid.
//
// Fixed point: every internal word is signed OUT_WIDTH bits carrying
// FRAC_BITS fraction bits. Right shifts are arithmetic (floor). There is
// no saturation; overflow wraps. FRAC_BITS must be at least 3 so that the
// 1/8 lifting taps keep fraction bits.
module fbindct_pipe #(
    parameter int IN_WIDTH  = 8,
    parameter int INT_BITS  = 4,
    parameter int FRAC_BITS = 6,
    parameter int OUT_WIDTH = IN_WIDTH + INT_BITS + FRAC_BITS,
    parameter int ROUND_OUT = 0
) (
    input  logic     clk,
    input  logic     rst,
    fbindct_if.slave bus
);
    localparam int W = OUT_WIDTH;
    typedef logic signed [W-1:0] word_t;

    // Half an output LSB in Q(FRAC_BITS), used for round-half-up.
    localparam word_t HALF = word_t'(1) <<< (FRAC_BITS - 1);

    // ------------------------------------------------------------------
    // Flow control: stage k can load when it is empty or when the stage
    // after it is moving on this cycle. An empty stage anywhere downstream
    // therefore lets everything above it advance (bubble collapse).
    // ------------------------------------------------------------------
    logic v1, v2, v3, v4;
    logic ready1, ready2, ready3, ready4;

    // Ready chain from the output backwards to the input.
    always_comb begin
        ready4 = !v4 || bus.out_ready;
        ready3 = !v3 || ready4;
        ready2 = !v2 || ready3;
        ready1 = !v1 || ready2;
    end

    assign bus.in_ready = ready1;

    // Stage valid bits: each loading stage takes the valid of its upstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            v4 <= 1'b0;
        end else begin
            if (ready1) v1 <= bus.in_valid;
            if (ready2) v2 <= v1;
            if (ready3) v3 <= v2;
            if (ready4) v4 <= v3;
        end
    end

    // ------------------------------------------------------------------
    // S1: butterfly sums/differences, scaled into Q(FRAC_BITS).
    // ------------------------------------------------------------------
    word_t sx     [8];
    word_t a_next [8];

    // Sign-extend each sample to the internal width and form the butterflies.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            sx[i] = word_t'(signed'(bus.x_in[i]));
        end
        a_next[0] = (sx[0] + sx[7]) <<< FRAC_BITS;
        a_next[1] = (sx[1] + sx[6]) <<< FRAC_BITS;
        a_next[2] = (sx[2] + sx[5]) <<< FRAC_BITS;
        a_next[3] = (sx[3] + sx[4]) <<< FRAC_BITS;
        a_next[4] = (sx[3] - sx[4]) <<< FRAC_BITS;
        a_next[5] = (sx[2] - sx[5]) <<< FRAC_BITS;
        a_next[6] = (sx[1] - sx[6]) <<< FRAC_BITS;
        a_next[7] = (sx[0] - sx[7]) <<< FRAC_BITS;
    end

    word_t s1_a [8];
    logic  s1_last;

    // S1 register: captures a new vector only when one is offered.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a    <= '{default: '0};
            s1_last <= 1'b0;
        end else if (ready1 && bus.in_valid) begin
            s1_a    <= a_next;
            s1_last <= bus.in_last;
        end
    end

    // ------------------------------------------------------------------
    // S2: lifting rotation of the odd pair (a5, a6). a5 and a6 are fully
    // consumed here, so only the other six butterfly terms travel on.
    // ------------------------------------------------------------------
    word_t b0_next, b1_next;

    // Two lifting steps: b0 from a5/a6, then b1 from b0/a5.
    always_comb begin
        b0_next = (s1_a[5] >>> 2) + (s1_a[5] >>> 3) + s1_a[6];
        b1_next = (b0_next >>> 1) + (b0_next >>> 3) - s1_a[5];
    end

    word_t s2_a0, s2_a1, s2_a2, s2_a3, s2_a4, s2_a7;
    word_t s2_b0, s2_b1;
    logic  s2_last;

    // S2 register: lifting results plus forwarded butterfly terms.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_a0   <= '0;
            s2_a1   <= '0;
            s2_a2   <= '0;
            s2_a3   <= '0;
            s2_a4   <= '0;
            s2_a7   <= '0;
            s2_b0   <= '0;
            s2_b1   <= '0;
            s2_last <= 1'b0;
        end else if (ready2 && v1) begin
            s2_a0   <= s1_a[0];
            s2_a1   <= s1_a[1];
            s2_a2   <= s1_a[2];
            s2_a3   <= s1_a[3];
            s2_a4   <= s1_a[4];
            s2_a7   <= s1_a[7];
            s2_b0   <= b0_next;
            s2_b1   <= b1_next;
            s2_last <= s1_last;
        end
    end

    // ------------------------------------------------------------------
    // S3: second butterfly layer.
    // ------------------------------------------------------------------
    word_t c_next [8];

    // Even half from the forwarded sums, odd half mixes in the lifting terms.
    always_comb begin
        c_next[0] = s2_a0 + s2_a3;
        c_next[1] = s2_a1 + s2_a2;
        c_next[2] = s2_a1 - s2_a2;
        c_next[3] = s2_a0 - s2_a3;
        c_next[4] = s2_a4 + s2_b1;
        c_next[5] = s2_a4 - s2_b1;
        c_next[6] = s2_a7 - s2_b0;
        c_next[7] = s2_a7 + s2_b0;
    end

    word_t s3_c [8];
    logic  s3_last;

    // S3 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_c    <= '{default: '0};
            s3_last <= 1'b0;
        end else if (ready3 && v2) begin
            s3_c    <= c_next;
            s3_last <= s2_last;
        end
    end

    // ------------------------------------------------------------------
    // S4: final lifting steps and reordering into coefficient order.
    // ------------------------------------------------------------------
    word_t d0, d1, d2, d3, d4, d5, d6;
    word_t y_next [8];

    // Final lifting network; c7 passes straight through as coefficient 1.
    always_comb begin
        d0 = s3_c[0] + s3_c[1];
        d1 = (d0 >>> 1) - s3_c[1];
        d2 = s3_c[2] - ((s3_c[3] >>> 2) + (s3_c[3] >>> 3));
        d3 = s3_c[3] + (d2 >>> 2) + (d2 >>> 3);
        d4 = s3_c[4] - (s3_c[7] >>> 3);
        d5 = s3_c[5] + (s3_c[6] >>> 1) + (s3_c[6] >>> 2) + (s3_c[6] >>> 3);
        d6 = s3_c[6] - (d5 >>> 1);

        y_next[0] = d0;
        y_next[1] = s3_c[7];
        y_next[2] = d3;
        y_next[3] = d6;
        y_next[4] = d1;
        y_next[5] = d5;
        y_next[6] = d2;
        y_next[7] = d4;
    end

    word_t s4_y [8];
    logic  s4_last;

    // S4 register: drives the output port and holds it during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            s4_y    <= '{default: '0};
            s4_last <= 1'b0;
        end else if (ready4 && v3) begin
            s4_y    <= y_next;
            s4_last <= s3_last;
        end
    end

    // ------------------------------------------------------------------
    // Output: raw Q(FRAC_BITS) or rounded to integer (half up), taken
    // combinationally from the S4 register so it is stable under stall.
    // ------------------------------------------------------------------

    // Optional rounding of each coefficient lane.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            if (ROUND_OUT != 0) begin
                bus.y_out[i] = (s4_y[i] + HALF) >>> FRAC_BITS;
            end else begin
                bus.y_out[i] = s4_y[i];
            end
        end
    end

    assign bus.out_valid = v4;
    assign bus.out_last  = s4_last;

endmodule

// File: tb/tb_fbindct_pipe.sv
// Bench for fbindct_pipe: one raw-output instance and one rounding instance
// driven by identical stimulus. Directed vectors with hand-worked results,
// a back-to-back stream, a long randomly stalled stream and a mid-stream
// reset. A negedge monitor keeps per-instance expected queues.
module tb_fbindct_pipe;
    localparam int IW = 8;
    localparam int FB = 6;
    localparam int OW = IW + 4 + FB;
    localparam int CW = 8 * OW + 2;

    typedef logic [7:0][IW-1:0] x_t;
    typedef logic [8*OW-1:0]    y_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fbindct_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus   ();
    fbindct_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus_r ();

    assign bus_r.x_in      = bus.x_in;
    assign bus_r.in_valid  = bus.in_valid;
    assign bus_r.in_last   = bus.in_last;
    assign bus_r.out_ready = bus.out_ready;

    fbindct_pipe #(.IN_WIDTH(IW), .INT_BITS(4), .FRAC_BITS(FB), .ROUND_OUT(0)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    fbindct_pipe #(.IN_WIDTH(IW), .INT_BITS(4), .FRAC_BITS(FB), .ROUND_OUT(1)) dut_r (
        .clk(clk), .rst(rst), .bus(bus_r)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic y_t dct_model(input x_t x);
        int s [8];
        int a [8];
        int c [8];
        int y [8];
        int b0, b1, d0, d1, d2, d3, d4, d5, d6;
        y_t r;
        for (int i = 0; i < 8; i++) s[i] = int'($signed(x[i]));
        a[0] = (s[0] + s[7]) * (2 ** FB);
        a[1] = (s[1] + s[6]) * (2 ** FB);
        a[2] = (s[2] + s[5]) * (2 ** FB);
        a[3] = (s[3] + s[4]) * (2 ** FB);
        a[4] = (s[3] - s[4]) * (2 ** FB);
        a[5] = (s[2] - s[5]) * (2 ** FB);
        a[6] = (s[1] - s[6]) * (2 ** FB);
        a[7] = (s[0] - s[7]) * (2 ** FB);
        b0 = (a[5] >>> 2) + (a[5] >>> 3) + a[6];
        b1 = (b0 >>> 1) + (b0 >>> 3) - a[5];
        c[0] = a[0] + a[3];
        c[1] = a[1] + a[2];
        c[2] = a[1] - a[2];
        c[3] = a[0] - a[3];
        c[4] = a[4] + b1;
        c[5] = a[4] - b1;
        c[6] = a[7] - b0;
        c[7] = a[7] + b0;
        d0 = c[0] + c[1];
        d1 = (d0 >>> 1) - c[1];
        d2 = c[2] - ((c[3] >>> 2) + (c[3] >>> 3));
        d3 = c[3] + (d2 >>> 2) + (d2 >>> 3);
        d4 = c[4] - (c[7] >>> 3);
        d5 = c[5] + (c[6] >>> 1) + (c[6] >>> 2) + (c[6] >>> 3);
        d6 = c[6] - (d5 >>> 1);
        y = '{d0, c[7], d3, d6, d1, d5, d2, d4};
        for (int i = 0; i < 8; i++) r[i*OW +: OW] = OW'(y[i]);
        return r;
    endfunction

    function automatic y_t rnd_pack(input y_t raw);
        y_t r;
        int v;
        for (int i = 0; i < 8; i++) begin
            v = int'($signed(raw[i*OW +: OW]));
            r[i*OW +: OW] = OW'((v + 2 ** (FB - 1)) >>> FB);
        end
        return r;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [CW-1:0] exp_q   [$];
    logic [CW-1:0] exp_r_q [$];
    int            emit_cyc [$];
    int            occ = 0;
    int            cyc_cnt = 0;
    logic          held = 1'b0, held_r = 1'b0;
    logic [CW-1:0] held_val, held_r_val;
    bit            rand_ready = 1'b0;

    always @(negedge clk) begin
        cyc_cnt++;
        if (rst) begin
            exp_q.delete();
            exp_r_q.delete();
            occ    = 0;
            held   = 1'b0;
            held_r = 1'b0;
        end else begin
            if (held)
                check("hold", {bus.out_valid, bus.out_last, bus.y_out}, held_val);
            if (held_r)
                check("hold_rnd", {bus_r.out_valid, bus_r.out_last, bus_r.y_out}, held_r_val);
            check("in_ready", CW'(bus.in_ready), CW'(!(occ == 4 && !bus.out_ready)));

            if (bus.out_valid && bus.out_ready) begin
                emit_cyc.push_back(cyc_cnt);
                if (exp_q.size() == 0) check("spurious_out", CW'(bus.out_valid), CW'(0));
                else check("out", {1'b1, bus.out_last, bus.y_out}, exp_q.pop_front());
            end
            if (bus_r.out_valid && bus_r.out_ready) begin
                if (exp_r_q.size() == 0) check("spurious_out_rnd", CW'(bus_r.out_valid), CW'(0));
                else check("out_rnd", {1'b1, bus_r.out_last, bus_r.y_out}, exp_r_q.pop_front());
            end

            if (bus.in_valid && bus.in_ready)
                exp_q.push_back({1'b1, bus.in_last, dct_model(bus.x_in)});
            if (bus_r.in_valid && bus_r.in_ready)
                exp_r_q.push_back({1'b1, bus.in_last, rnd_pack(dct_model(bus.x_in))});

            occ = occ + int'(bus.in_valid && bus.in_ready) - int'(bus.out_valid && bus.out_ready);

            held       = bus.out_valid && !bus.out_ready;
            held_val   = {bus.out_valid, bus.out_last, bus.y_out};
            held_r     = bus_r.out_valid && !bus_r.out_ready;
            held_r_val = {bus_r.out_valid, bus_r.out_last, bus_r.y_out};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input x_t x, input logic last);
        bit acc;
        int n;
        bus.x_in     = x;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            n++;
        end while (!acc && n < 100);
        if (!acc) check("send_timeout", CW'(acc), CW'(1));
        bus.in_valid = 1'b0;
    endtask

    function automatic x_t mk_x(input int e [8]);
        x_t v;
        for (int i = 0; i < 8; i++) v[i] = IW'(e[i]);
        return v;
    endfunction

    function automatic x_t rand_x();
        x_t v;
        for (int i = 0; i < 8; i++) v[i] = IW'($urandom_range(0, 255));
        return v;
    endfunction

    // Send one vector into an empty pipe and check latency and every lane.
    task automatic directed(input string tag, input x_t x, input int er [8], input int eq [8]);
        int cyc;
        logic [OW-1:0] ev;
        send(x, 1'b0);
        cyc = 1;
        while (!bus.out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, CW'(cyc), CW'(4));
        for (int i = 0; i < 8; i++) begin
            ev = OW'(er[i]);
            check($sformatf("%s_y%0d", tag, i), CW'(bus.y_out[i]), CW'(ev));
            ev = OW'(eq[i]);
            check($sformatf("%s_rnd_y%0d", tag, i), CW'(bus_r.y_out[i]), CW'(ev));
        end
        repeat (3) tick();
    endtask

    // ---------------- main sequence ----------------
    int e_in [8];
    int e_raw [8];
    int e_rnd [8];
    int n;
    x_t xv;

    initial begin
        bus.x_in      = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", CW'(bus.out_valid), CW'(0));
        check("rst_y", CW'(bus.y_out), CW'(0));
        check("rst_last", CW'(bus.out_last), CW'(0));
        check("rst_ready", CW'(bus.in_ready), CW'(1));
        check("rst_rnd_y", CW'(bus_r.y_out), CW'(0));
        rst = 1'b0;
        tick();

        // DC input: only the DC coefficient is nonzero.
        e_in  = '{10, 10, 10, 10, 10, 10, 10, 10};
        e_raw = '{5120, 0, 0, 0, 0, 0, 0, 0};
        e_rnd = '{80, 0, 0, 0, 0, 0, 0, 0};
        directed("dc", mk_x(e_in), e_raw, e_rnd);

        // Unit impulse on x0.
        e_in  = '{1, 0, 0, 0, 0, 0, 0, 0};
        e_raw = '{64, 64, 55, 36, 32, 56, -24, -8};
        e_rnd = '{1, 1, 1, 1, 1, 1, 0, 0};
        directed("imp", mk_x(e_in), e_raw, e_rnd);

        // Most negative DC input.
        e_in  = '{-128, -128, -128, -128, -128, -128, -128, -128};
        e_raw = '{-65536, 0, 0, 0, 0, 0, 0, 0};
        e_rnd = '{-1024, 0, 0, 0, 0, 0, 0, 0};
        directed("neg", mk_x(e_in), e_raw, e_rnd);

        // Alternating extremes, checked against the model by the monitor.
        e_in = '{127, -128, 127, -128, 127, -128, 127, -128};
        send(mk_x(e_in), 1'b1);
        repeat (6) tick();

        // Back-to-back stream of 16, LAST on the 8th and 16th.
        emit_cyc.delete();
        for (int i = 0; i < 16; i++) send(rand_x(), (i == 7 || i == 15));
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("t3_count", CW'(emit_cyc.size()), CW'(16));
        if (emit_cyc.size() == 16)
            check("t3_span", CW'(emit_cyc[15] - emit_cyc[0]), CW'(15));

        // Long stream with random input gaps and random output stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
            send(rand_x(), 1'($urandom_range(0, 1)));
        end
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || exp_r_q.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        check("t4_drain", CW'(exp_q.size()), CW'(0));
        check("t4_drain_rnd", CW'(exp_r_q.size()), CW'(0));

        // Reset with three vectors in flight.
        for (int i = 0; i < 3; i++) send(rand_x(), 1'b1);
        rst = 1'b1;
        tick();
        check("mrst_valid", CW'(bus.out_valid), CW'(0));
        check("mrst_y", CW'(bus.y_out), CW'(0));
        check("mrst_last", CW'(bus.out_last), CW'(0));
        check("mrst_ready", CW'(bus.in_ready), CW'(1));
        check("mrst_rnd_valid", CW'(bus_r.out_valid), CW'(0));
        rst = 1'b0;
        tick();
        e_in = '{3, -7, 25, 0, -90, 44, 1, -2};
        xv = mk_x(e_in);
        send(xv, 1'b1);
        n = 1;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("mrst_lat", CW'(n), CW'(4));
        check("mrst_first", {2'b01, bus.out_last, bus.y_out} , {2'b01, 1'b1, dct_model(xv)});
        repeat (4) tick();
        check("final_q", CW'(exp_q.size()), CW'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
